// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and parity mode codes,
// common to the TX and RX blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Parity bit over up to 9 data bits; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop
// bits, paced by an external oversampling tick. Idle line is high.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_tick,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned S_W = $clog2(OVERSAMPLE);
  localparam int unsigned N_W = $clog2(DATA_WIDTH);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [S_W-1:0]        s_q, s_d;
  logic [N_W-1:0]        n_q, n_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  two_stop_q, two_stop_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic                  bit_end;
  logic [N_W-1:0]        stop_last;

  assign tx_ready  = (state_q == ST_IDLE);
  assign accept    = tx_valid & tx_ready;
  assign bit_end   = s_tick && (s_q == S_LAST);
  // The bit counter doubles as the stop-bit counter: 0 only, or 0 then 1.
  assign stop_last = {{(N_W-1){1'b0}}, two_stop_q};

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

  // Next-state, counters and line value; tx is derived from the next state so
  // the registered line lines up with the registered state.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q != ST_IDLE && s_tick) begin
      s_d = bit_end ? '0 : s_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_START;
          s_d        = '0;
          n_d        = '0;
          shift_d    = din;
          par_en_d   = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
          par_bit_d  = calc_parity(9'(din), parity_mode == PAR_ODD);
          two_stop_d = two_stop;
          busy_d     = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (n_q == N_LAST) begin
            n_d     = '0;
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          n_d     = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (n_q == stop_last) begin
            n_d     = '0;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_bit_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // State and output registers with synchronous reset to an idle-high line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      n_q        <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      n_q        <= n_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frames are captured one bit period
// (OVERSAMPLE ticks) at a time and compared with hand-built line patterns,
// where bit i of a pattern is the i-th bit on the line.
module tb_uart_tx_cfg;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] din = '0;
  logic [1:0] parity_mode = 2'b00;
  logic       two_stop = 1'b0;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int n_cmp = 0;
  int n_err = 0;
  logic irregular = 1'b0;

  uart_tx_cfg #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .din(din), .parity_mode(parity_mode),
    .two_stop(two_stop), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  function automatic logic next_tick();
    if (irregular) return ($urandom_range(0, 6) == 0);
    return 1'b1;
  endfunction

  // Present one word for a single cycle; returns on the first cycle of the frame.
  task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic ts);
    din = d; parity_mode = pm; two_stop = ts; tx_valid = 1'b1;
    s_tick = next_tick();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Record the line value for each bit period; an unstable period reads as x.
  // Optionally changes the config inputs at the start of period chg_seg.
  task automatic capture(input int nseg, input int chg_seg, input logic [1:0] new_pm,
                         input logic new_ts, output logic [15:0] segv, output int ncyc,
                         output logic done_end, output logic done_early,
                         output logic rdy_low, output logic busy_high, output logic tmo);
    int cyc;
    cyc = 0; segv = '0; done_early = 1'b0; rdy_low = 1'b1; busy_high = 1'b1; tmo = 1'b0;
    for (int i = 0; i < nseg && !tmo; i++) begin
      int cnt;
      logic v;
      cnt = 0;
      if (i == chg_seg) begin parity_mode = new_pm; two_stop = new_ts; end
      v = tx;
      while (cnt < OS && !tmo) begin
        if (tx !== v) v = 1'bx;
        if (tx_done) done_early = 1'b1;
        if (tx_ready) rdy_low = 1'b0;
        if (!tx_busy) busy_high = 1'b0;
        s_tick = next_tick();
        if (s_tick) cnt++;
        @(negedge clk);
        cyc++;
        if (cyc > 4000) tmo = 1'b1;
      end
      segv[i] = v;
    end
    ncyc = cyc;
    done_end = tx_done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    n_cmp++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", tx_done); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_8n1();
    logic [15:0] segv; int ncyc; logic de, dearly, rl, bh, tmo;
    irregular = 1'b0;
    send(8'hA5, 2'b00, 1'b0);
    capture(10, -1, 2'b00, 1'b0, segv, ncyc, de, dearly, rl, bh, tmo);
    // {stop, A5, start} = 1_10100101_0
    n_cmp++; if (segv !== 16'h034A) begin n_err++; $display("FAIL 8n1_line: got %h expected 034a", segv); end
    n_cmp++; if (ncyc !== 160) begin n_err++; $display("FAIL 8n1_cycles: got %0d expected 160", ncyc); end
    n_cmp++; if (de !== 1'b1) begin n_err++; $display("FAIL 8n1_done: got %b expected 1", de); end
    n_cmp++; if (dearly !== 1'b0) begin n_err++; $display("FAIL 8n1_done_early: got %b expected 0", dearly); end
    n_cmp++; if (bh !== 1'b1) begin n_err++; $display("FAIL 8n1_busy: got %b expected 1", bh); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL 8n1_busy_end: got %b expected 0", tx_busy); end
    n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL 8n1_timeout: got %b expected 0", tmo); end
    s_tick = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL 8n1_done_pulse: got %b expected 0", tx_done); end
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL 8n1_idle_line: got %b expected 1", tx); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_parity_stop();
    logic [15:0] segv; int ncyc; logic de, dearly, rl, bh, tmo;
    irregular = 1'b0;
    // even parity: {stop, par=1, 07, start}
    send(8'h07, 2'b01, 1'b0);
    capture(11, -1, 2'b00, 1'b0, segv, ncyc, de, dearly, rl, bh, tmo);
    n_cmp++; if (segv !== 16'h060E) begin n_err++; $display("FAIL par_even_line: got %h expected 060e", segv); end
    n_cmp++; if (de !== 1'b1) begin n_err++; $display("FAIL par_even_done: got %b expected 1", de); end
    repeat (4) @(negedge clk);
    // odd parity, two stop bits: {stop, stop, par=0, 07, start}
    send(8'h07, 2'b10, 1'b1);
    capture(12, -1, 2'b00, 1'b0, segv, ncyc, de, dearly, rl, bh, tmo);
    n_cmp++; if (segv !== 16'h0C0E) begin n_err++; $display("FAIL par_odd_2stop_line: got %h expected 0c0e", segv); end
    n_cmp++; if (de !== 1'b1) begin n_err++; $display("FAIL par_odd_2stop_done: got %b expected 1", de); end
    n_cmp++; if (dearly !== 1'b0) begin n_err++; $display("FAIL par_odd_2stop_early: got %b expected 0", dearly); end
    repeat (4) @(negedge clk);
    // mode 11 sends no parity bit
    send(8'h07, 2'b11, 1'b0);
    capture(10, -1, 2'b00, 1'b0, segv, ncyc, de, dearly, rl, bh, tmo);
    n_cmp++; if (segv !== 16'h020E) begin n_err++; $display("FAIL par_mode3_line: got %h expected 020e", segv); end
    n_cmp++; if (de !== 1'b1) begin n_err++; $display("FAIL par_mode3_done: got %b expected 1", de); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] segv; int ncyc; logic de, dearly, rl, bh, tmo;
    irregular = 1'b0;
    din = 8'h55; parity_mode = 2'b00; two_stop = 1'b0; tx_valid = 1'b1; s_tick = 1'b1;
    @(negedge clk);
    din = 8'h0F;
    capture(10, -1, 2'b00, 1'b0, segv, ncyc, de, dearly, rl, bh, tmo);
    n_cmp++; if (segv !== 16'h02AA) begin n_err++; $display("FAIL b2b_first_line: got %h expected 02aa", segv); end
    n_cmp++; if (rl !== 1'b1) begin n_err++; $display("FAIL b2b_first_ready_low: got %b expected 1", rl); end
    n_cmp++; if (de !== 1'b1) begin n_err++; $display("FAIL b2b_first_done: got %b expected 1", de); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_at_done: got %b expected 1", tx_ready); end
    s_tick = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    capture(10, -1, 2'b00, 1'b0, segv, ncyc, de, dearly, rl, bh, tmo);
    n_cmp++; if (segv !== 16'h021E) begin n_err++; $display("FAIL b2b_second_line: got %h expected 021e", segv); end
    n_cmp++; if (rl !== 1'b1) begin n_err++; $display("FAIL b2b_second_ready_low: got %b expected 1", rl); end
    n_cmp++; if (ncyc !== 160) begin n_err++; $display("FAIL b2b_second_cycles: got %0d expected 160", ncyc); end
    n_cmp++; if (de !== 1'b1) begin n_err++; $display("FAIL b2b_second_done: got %b expected 1", de); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_irregular_tick_cfg();
    logic [15:0] segv; int ncyc; logic de, dearly, rl, bh, tmo;
    irregular = 1'b1;
    // config moves to odd parity / two stops mid-frame: frame stays 8N1
    send(8'h3C, 2'b00, 1'b0);
    capture(10, 4, 2'b10, 1'b1, segv, ncyc, de, dearly, rl, bh, tmo);
    n_cmp++; if (segv !== 16'h0278) begin n_err++; $display("FAIL irr_8n1_line: got %h expected 0278", segv); end
    n_cmp++; if (de !== 1'b1) begin n_err++; $display("FAIL irr_8n1_done: got %b expected 1", de); end
    n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL irr_8n1_timeout: got %b expected 0", tmo); end
    repeat (3) @(negedge clk);
    // config drops parity / second stop mid-frame: frame keeps them
    send(8'h07, 2'b01, 1'b1);
    capture(12, 2, 2'b00, 1'b0, segv, ncyc, de, dearly, rl, bh, tmo);
    n_cmp++; if (segv !== 16'h0E0E) begin n_err++; $display("FAIL irr_8e2_line: got %h expected 0e0e", segv); end
    n_cmp++; if (de !== 1'b1) begin n_err++; $display("FAIL irr_8e2_done: got %b expected 1", de); end
    n_cmp++; if (dearly !== 1'b0) begin n_err++; $display("FAIL irr_8e2_early: got %b expected 0", dearly); end
    irregular = 1'b0;
    parity_mode = 2'b00; two_stop = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] segv; int ncyc; logic de, dearly, rl, bh, tmo;
    logic saw_done; logic line_low;
    irregular = 1'b0;
    saw_done = 1'b0;
    send(8'hA5, 2'b00, 1'b0);
    repeat (68) begin
      if (tx_done) saw_done = 1'b1;
      s_tick = 1'b1;
      @(negedge clk);
    end
    // now inside data bit 3 of A5, which is 0
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL rst_mid_bit3: got %b expected 0", tx); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL rst_mid_tx: got %b expected 1", tx); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", tx_busy); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b expected 1", tx_ready); end
    reset = 1'b0;
    line_low = 1'b0;
    repeat (40) begin
      if (tx_done) saw_done = 1'b1;
      if (tx !== 1'b1) line_low = 1'b1;
      s_tick = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_done: got %b expected 0", saw_done); end
    n_cmp++; if (line_low !== 1'b0) begin n_err++; $display("FAIL rst_mid_line_idle: got %b expected 0", line_low); end
    send(8'h96, 2'b00, 1'b0);
    capture(10, -1, 2'b00, 1'b0, segv, ncyc, de, dearly, rl, bh, tmo);
    n_cmp++; if (segv !== 16'h032C) begin n_err++; $display("FAIL rst_mid_clean_line: got %h expected 032c", segv); end
    n_cmp++; if (de !== 1'b1) begin n_err++; $display("FAIL rst_mid_clean_done: got %b expected 1", de); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_8n1();
    test_parity_stop();
    test_back_to_back();
    test_irregular_tick_cfg();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
